// File: rtl/scp_loader_pkg.sv
// Shared types and constants for the SCP boot loader.
package scp_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam int unsigned EDIT_WIDTH_MAX = 15;
    localparam logic [7:0]  CKSUM_OK       = 8'h00;

endpackage

// File: rtl/scp_mem_loader.sv
// Streams a checksummed image into SCP's memory-edit port while holding the CPU in reset.
// Latency: 1 cycle per header/check byte, EDIT_WIDTH+3 per data byte; stalls indefinitely on IN_VALID low.
module scp_mem_loader
    import scp_loader_pkg::*;
#(
    parameter int unsigned EDIT_WIDTH = 1
) (
    input  logic       CLK,
    input  logic       AR,
    input  logic       LOAD_START,
    input  logic [7:0] IN_DATA,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic [7:0] MEM_ADDR,
    output logic [7:0] MEM_DATA,
    output logic       MEM_EDIT,
    output logic       CPU_HOLD,
    output logic       DONE,
    output logic       ERR
);

    localparam logic [3:0] STROBE_LAST = 4'(EDIT_WIDTH - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] addr_q;
    logic [7:0] sum_q;
    logic [7:0] sum_add;
    logic [8:0] remaining_q;
    logic [3:0] width_cnt;
    logic       accept;

    assign IN_READY = (state == S_ADDR) || (state == S_LEN) ||
                      (state == S_DATA) || (state == S_CHECK);
    assign accept   = IN_VALID && IN_READY;
    assign sum_add  = sum_q + IN_DATA;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (LOAD_START) state_nxt = S_ADDR;
            S_ADDR:   if (accept) state_nxt = S_LEN;
            S_LEN:    if (accept) state_nxt = S_DATA;
            S_DATA:   if (accept) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_STROBE;
            S_STROBE: if (width_cnt == STROBE_LAST) state_nxt = S_HOLD;
            S_HOLD:   state_nxt = (remaining_q != 9'd0) ? S_DATA : S_CHECK;
            S_CHECK:  if (accept) state_nxt = (sum_add == CKSUM_OK) ? S_DONE : S_ERR;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are flops fed from the next state so the SCP-facing strobe never glitches.
    always_ff @(posedge CLK or negedge AR) begin
        if (!AR) begin
            state       <= S_IDLE;
            addr_q      <= 8'h00;
            sum_q       <= 8'h00;
            remaining_q <= 9'd0;
            width_cnt   <= 4'd0;
            MEM_ADDR    <= 8'h00;
            MEM_DATA    <= 8'h00;
            MEM_EDIT    <= 1'b0;
            CPU_HOLD    <= 1'b1;
            DONE        <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            state    <= state_nxt;
            MEM_EDIT <= (state_nxt == S_STROBE);
            DONE     <= (state_nxt == S_DONE);
            ERR      <= (state_nxt == S_ERR);
            CPU_HOLD <= (state_nxt != S_DONE);
            case (state)
                S_ADDR: if (accept) begin
                    addr_q <= IN_DATA;
                    sum_q  <= IN_DATA;
                end
                S_LEN: if (accept) begin
                    remaining_q <= (IN_DATA == 8'h00) ? 9'd256 : {1'b0, IN_DATA};
                    sum_q       <= sum_add;
                end
                S_DATA: if (accept) begin
                    MEM_ADDR    <= addr_q;
                    MEM_DATA    <= IN_DATA;
                    sum_q       <= sum_add;
                    remaining_q <= remaining_q - 9'd1;
                    addr_q      <= addr_q + 8'd1;
                end
                S_SETUP:  width_cnt <= 4'd0;
                S_STROBE: width_cnt <= width_cnt + 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scp_mem_loader.sv
// Scoreboarded bench for scp_mem_loader: expected writes queued at stimulus time, popped on each MEM_EDIT pulse.
module tb_scp_mem_loader;

    localparam int EW = 3;

    logic       CLK = 1'b0;
    logic       AR = 1'b0;
    logic       LOAD_START = 1'b0;
    logic [7:0] IN_DATA = 8'h00;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [7:0] MEM_ADDR;
    logic [7:0] MEM_DATA;
    logic       MEM_EDIT;
    logic       CPU_HOLD;
    logic       DONE;
    logic       ERR;

    scp_mem_loader #(.EDIT_WIDTH(EW)) dut (
        .CLK        (CLK),
        .AR         (AR),
        .LOAD_START (LOAD_START),
        .IN_DATA    (IN_DATA),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_DATA   (MEM_DATA),
        .MEM_EDIT   (MEM_EDIT),
        .CPU_HOLD   (CPU_HOLD),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    wr_t        exp_q[$];
    int         acc_q[$];
    logic [7:0] bq[$];
    bit         abort_pulse = 1'b0;
    bit         gaps = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected write per MEM_EDIT pulse and checks its width and stability.
    logic prev_edit = 1'b0;
    int   width = 0;
    wr_t  cur = '0;
    always @(negedge CLK) begin
        if (MEM_EDIT && !prev_edit) begin
            width = 1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", MEM_ADDR, MEM_DATA);
            end else begin
                cur = exp_q.pop_front();
                check("write_addr", {24'd0, MEM_ADDR}, {24'd0, cur.a});
                check("write_data", {24'd0, MEM_DATA}, {24'd0, cur.d});
            end
        end else if (MEM_EDIT) begin
            width++;
        end else if (prev_edit) begin
            if (!abort_pulse) begin
                check("strobe_width", width, EW);
                check("hold_addr", {24'd0, MEM_ADDR}, {24'd0, cur.a});
                check("hold_data", {24'd0, MEM_DATA}, {24'd0, cur.d});
            end
            abort_pulse = 1'b0;
        end
        prev_edit = MEM_EDIT;
    end

    task automatic send_byte(input logic [7:0] b);
        bit rdy;
        int n;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            IN_VALID = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge CLK);
            #1;
        end
        IN_DATA  = b;
        IN_VALID = 1'b1;
        rdy = 1'b0;
        n = 0;
        while (!rdy && n < 200) begin
            @(negedge CLK);
            rdy = IN_READY;
            @(posedge CLK);
            n++;
        end
        #1;
        acc_q.push_back(cyc);
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no IN_READY for byte %0h expected accept within 200 cycles", b);
        end
        if (gaps) IN_VALID = 1'b0;
    endtask

    task automatic start_load();
        LOAD_START = 1'b1;
        @(posedge CLK);
        #1;
        LOAD_START = 1'b0;
    endtask

    task automatic stream(input logic [7:0] s[$]);
        acc_q.delete();
        foreach (s[i]) send_byte(s[i]);
        IN_VALID = 1'b0;
        @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int n;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_in_ready", {31'd0, IN_READY}, 32'd0);
        check("rst_mem_addr", {24'd0, MEM_ADDR}, 32'h00);
        check("rst_mem_data", {24'd0, MEM_DATA}, 32'h00);
        check("rst_mem_edit", {31'd0, MEM_EDIT}, 32'd0);
        check("rst_cpu_hold", {31'd0, CPU_HOLD}, 32'd1);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_err", {31'd0, ERR}, 32'd0);
        @(negedge CLK);
        AR = 1'b1;
        @(posedge CLK);
        #1;

        // Good load, IN_VALID held high throughout.
        exp_q.push_back('{8'h10, 8'hAA});
        exp_q.push_back('{8'h11, 8'h55});
        start_load();
        bq = '{8'h10, 8'h02, 8'hAA, 8'h55, 8'hEF};
        stream(bq);
        check("good_done", {31'd0, DONE}, 32'd1);
        check("good_cpu_hold", {31'd0, CPU_HOLD}, 32'd0);
        check("good_err", {31'd0, ERR}, 32'd0);
        check("good_pending", exp_q.size(), 32'd0);
        check("data_byte_period", acc_q[3] - acc_q[2], EW + 3);

        // Bad checksum.
        exp_q.push_back('{8'h10, 8'hAA});
        exp_q.push_back('{8'h11, 8'h55});
        start_load();
        bq = '{8'h10, 8'h02, 8'hAA, 8'h55, 8'hEE};
        stream(bq);
        check("bad_err", {31'd0, ERR}, 32'd1);
        check("bad_cpu_hold", {31'd0, CPU_HOLD}, 32'd1);
        check("bad_done", {31'd0, DONE}, 32'd0);

        // Restart from error, then an address-wrapping image.
        start_load();
        check("restart_in_ready", {31'd0, IN_READY}, 32'd1);
        check("restart_err", {31'd0, ERR}, 32'd0);
        check("restart_cpu_hold", {31'd0, CPU_HOLD}, 32'd1);
        exp_q.push_back('{8'hFF, 8'h01});
        exp_q.push_back('{8'h00, 8'h02});
        bq = '{8'hFF, 8'h02, 8'h01, 8'h02, 8'hFC};
        stream(bq);
        check("wrap_done", {31'd0, DONE}, 32'd1);
        check("wrap_pending", exp_q.size(), 32'd0);

        // LEN=0 is a full 256-byte image.
        bq.delete();
        bq.push_back(8'h00);
        bq.push_back(8'h00);
        for (int i = 0; i < 256; i++) begin
            bq.push_back(8'(i));
            exp_q.push_back('{8'(i), 8'(i)});
        end
        bq.push_back(8'h80);
        start_load();
        stream(bq);
        check("len0_done", {31'd0, DONE}, 32'd1);
        check("len0_err", {31'd0, ERR}, 32'd0);
        check("len0_pending", exp_q.size(), 32'd0);

        // Random IN_VALID gaps.
        gaps = 1'b1;
        exp_q.push_back('{8'h40, 8'h01});
        exp_q.push_back('{8'h41, 8'h02});
        exp_q.push_back('{8'h42, 8'h03});
        start_load();
        bq = '{8'h40, 8'h03, 8'h01, 8'h02, 8'h03, 8'hB7};
        stream(bq);
        gaps = 1'b0;
        check("gaps_done", {31'd0, DONE}, 32'd1);
        check("gaps_pending", exp_q.size(), 32'd0);

        // Reset asserted during the strobe.
        exp_q.push_back('{8'h20, 8'h77});
        start_load();
        send_byte(8'h20);
        send_byte(8'h01);
        send_byte(8'h77);
        n = 0;
        while (!MEM_EDIT && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("strobe_seen", {31'd0, MEM_EDIT}, 32'd1);
        #2;
        abort_pulse = 1'b1;
        AR = 1'b0;
        #1;
        check("arst_mem_edit", {31'd0, MEM_EDIT}, 32'd0);
        check("arst_cpu_hold", {31'd0, CPU_HOLD}, 32'd1);
        check("arst_done", {31'd0, DONE}, 32'd0);
        @(negedge CLK);
        #2;
        AR = 1'b1;
        IN_VALID = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge CLK);
            if (IN_READY || MEM_EDIT || DONE || ERR || !CPU_HOLD) cnt++;
        end
        IN_VALID = 1'b0;
        check("post_reset_quiet", cnt, 32'd0);
        check("post_reset_pending", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scp_mem_loader.md
# scp_mem_loader

Boot loader that drives the SCP memory-edit port (MEM_ADDR / MEM_DATA / MEM_EDIT) from a byte stream, while holding the CPU in reset. It sits outside SCP, between a host byte source and SCP's asynchronous memory-set inputs. It releases the CPU only after a checksummed image has been written completely.

## Interface
- EDIT_WIDTH, default 1: cycles MEM_EDIT is held high per byte (1..15).
- CLK  in  1  system clock; all state changes on the rising edge.
- AR  in  1  reset; one clock; reset is asynchronous and active-low.
- LOAD_START  in  1  one-cycle request to begin a load.
- IN_DATA  in  8  stream byte.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  loader accepts IN_DATA this cycle.
- MEM_ADDR  out  8  address to SCP memory-edit port.
- MEM_DATA  out  8  data to SCP memory-edit port.
- MEM_EDIT  out  1  memory-set strobe to SCP (registered, glitch-free).
- CPU_HOLD  out  1  drives SCP reset; 1 = CPU held in reset.
- DONE  out  1  image loaded and checksum good.
- ERR  out  1  checksum mismatch.

## Operation
- Stream format: START_ADDR, LEN, LEN data bytes, CHECK. LEN = 0 means 256 bytes.
- Validity: the 8-bit sum of all bytes, including CHECK, must be 0x00.
- Byte transfer: a byte is taken on a rising edge with IN_VALID & IN_READY.
- IN_READY is high only in S_ADDR, S_LEN, S_DATA and S_CHECK.
- States:
  - S_IDLE: CPU_HOLD=1. LOAD_START → S_ADDR.
  - S_ADDR: accept → addr reg = byte, sum = byte → S_LEN.
  - S_LEN: accept → remaining (9-bit) = (byte==0) ? 256 : byte; sum += byte → S_DATA.
  - S_DATA: accept → MEM_ADDR = addr, MEM_DATA = byte, sum += byte, remaining −1, addr +1 (mod 256, 0xFF wraps to 0x00) → S_SETUP.
  - S_SETUP: 1 cycle, MEM_EDIT=0 → S_STROBE.
  - S_STROBE: EDIT_WIDTH cycles, MEM_EDIT=1 → S_HOLD.
  - S_HOLD: 1 cycle, MEM_EDIT=0. Goes to S_DATA if remaining≠0, else S_CHECK.
  - S_CHECK: accept → if sum+byte == 0, S_DONE; else S_ERR.
  - S_DONE: DONE=1, CPU_HOLD=0.
  - S_ERR: ERR=1, CPU_HOLD=1.
  - From S_DONE or S_ERR, LOAD_START → S_ADDR, with DONE, ERR and CPU_HOLD updated at the same edge.
- LOAD_START is ignored in S_ADDR through S_CHECK.
- MEM_ADDR and MEM_DATA are stable from S_SETUP through S_HOLD. They keep their last value otherwise.
- Reset values: IN_READY=0, MEM_ADDR=0x00, MEM_DATA=0x00, MEM_EDIT=0, CPU_HOLD=1, DONE=0, ERR=0, state S_IDLE, sum=0, remaining=0.
- Reset mid-load (AR low in any state) takes effect asynchronously:
  - MEM_EDIT drops and CPU_HOLD rises immediately.
  - No partial-image completion is claimed.
  - The loader restarts only on a new LOAD_START.

## Timing
- All outputs are registered; the only combinational path is none. IN_READY is a state decode from registers.
- Per data byte, with IN_VALID held high: EDIT_WIDTH+3 cycles, i.e. 1 accept + 1 setup + EDIT_WIDTH strobe + 1 hold.
- Header: 1 cycle per byte. CHECK: 1 cycle.
- CPU_HOLD falls at the same edge DONE rises, 1 cycle after CHECK is accepted.
- MEM_EDIT rises at least 1 full cycle after MEM_ADDR/MEM_DATA change and falls at least 1 cycle before they change again. This gives setup/hold margin for SCP's asynchronous memory set.
- IN_VALID may drop at any time. The loader stalls in its current accepting state with no timeout.

## Structure
- Package scp_loader_pkg holds:
  - the state enum (S_IDLE … S_ERR);
  - EDIT_WIDTH_MAX = 15;
  - CKSUM_OK = 8'h00.
- Single module, no sub-modules. The strobe-width counter (4-bit), the remaining counter (9-bit) and the checksum accumulator (8-bit) are inline.

## Test plan
- Good load: LOAD_START, then stream 0x10, 0x02, 0xAA, 0x55, 0xEF (EDIT_WIDTH=1) → two MEM_EDIT pulses writing (0x10,0xAA) and (0x11,0x55); DONE=1, CPU_HOLD=0, ERR=0.
- Bad checksum: same stream ending 0xEE → ERR=1, CPU_HOLD stays 1, DONE=0. A following LOAD_START clears ERR and raises IN_READY in S_ADDR.
- Wrap: 0xFF, 0x02, 0x01, 0x02, 0xFC → writes (0xFF,0x01) then (0x00,0x02); DONE=1.
- LEN=0: 0x00, 0x00, then 256 bytes i mod 256, then a correct CHECK → exactly 256 MEM_EDIT pulses at addresses 0x00..0xFF.
- Throughput and backpressure: IN_VALID held high with EDIT_WIDTH=3 → IN_READY high 1 cycle in every 6 during data, and MEM_EDIT high for exactly 3 cycles. Random IN_VALID gaps leave the written contents unchanged.
- Reset mid-strobe: AR low during S_STROBE → MEM_EDIT=0 and CPU_HOLD=1 before the next CLK edge; DONE=0. After AR rises, no activity occurs until LOAD_START.
